// File: rtl/memory_bus_master.sv
// Load/store sequencer between the execute stage and the bank-routing memory bus.
// Define MISALIGN_TRAP_EN to complete misaligned accesses with rsp_error instead of aligning them.
module memory_bus_master #(
   parameter int unsigned READ_WAIT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [15:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [15:0] bus_address,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_write_mask,
   output logic        bus_enable,
   output logic        bus_write_enable,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  dbg_state
);

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic [1:0]  lat_size, lat_size_n;
   logic        lat_signed, lat_signed_n;
   logic [1:0]  lat_off, lat_off_n;
   logic        req_ready_n, rsp_valid_n, rsp_error_n;
   logic [31:0] rsp_rdata_n;
   logic [15:0] bus_address_n;
   logic [31:0] bus_wdata_n;
   logic [3:0]  bus_write_mask_n;
   logic        bus_enable_n, bus_write_enable_n;
   logic        misaligned;
   logic [31:0] store_data, load_data;
   logic [3:0]  store_mask;
   logic [7:0]  load_byte;
   logic [15:0] load_half;

   assign dbg_state = state;

   assign misaligned = ((req_size == 2'b01) && req_address[0]) ||
                       (req_size[1] && (req_address[1:0] != 2'b00));

   // A mask bit of 1 protects its byte lane, so only the addressed lanes are cleared.
   always_comb begin
      store_data = req_wdata;
      store_mask = 4'h0;
      case (req_size)
         2'b00: begin
            store_data = {4{req_wdata[7:0]}};
            store_mask = ~(4'b0001 << req_address[1:0]);
         end
         2'b01: begin
            store_data = {2{req_wdata[15:0]}};
            store_mask = req_address[1] ? 4'b0011 : 4'b1100;
         end
         default: ;
      endcase
   end

   always_comb begin
      load_byte = bus_rdata[{lat_off, 3'b000} +: 8];
      load_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (lat_size)
         2'b00:   load_data = {{24{lat_signed & load_byte[7]}}, load_byte};
         2'b01:   load_data = {{16{lat_signed & load_half[15]}}, load_half};
         default: load_data = bus_rdata;
      endcase
   end

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
   // req_valid is ignored otherwise, and rsp_valid is a single-cycle pulse with no back-pressure.
   always_comb begin
      state_n            = state;
      cnt_n              = cnt;
      lat_size_n         = lat_size;
      lat_signed_n       = lat_signed;
      lat_off_n          = lat_off;
      rsp_rdata_n        = 32'h0;
      rsp_error_n        = 1'b0;
      bus_address_n      = bus_address;
      bus_wdata_n        = bus_wdata;
      bus_write_mask_n   = 4'hF;
      bus_enable_n       = 1'b0;
      bus_write_enable_n = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               lat_size_n   = req_size;
               lat_signed_n = req_signed;
               lat_off_n    = req_address[1:0];
               if (misaligned && TRAP_EN) begin
                  state_n     = RESP;
                  rsp_error_n = 1'b1;
               end else begin
                  bus_address_n = {req_address[15:2], 2'b00};
                  bus_enable_n  = 1'b1;
                  if (req_write) begin
                     state_n            = WRITE;
                     bus_write_enable_n = 1'b1;
                     bus_write_mask_n   = store_mask;
                     bus_wdata_n        = store_data;
                  end else begin
                     state_n = READ;
                     cnt_n   = WAIT_INIT;
                  end
               end
            end
         end
         WRITE: state_n = RESP;
         READ: begin
            if (cnt == 3'd0) begin
               state_n     = RESP;
               rsp_rdata_n = load_data;
            end else begin
               cnt_n        = cnt - 3'd1;
               bus_enable_n = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      rsp_valid_n = (state_n == RESP);
      req_ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         cnt              <= 3'd0;
         lat_size         <= 2'b00;
         lat_signed       <= 1'b0;
         lat_off          <= 2'b00;
         req_ready        <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_rdata        <= 32'h0;
         rsp_error        <= 1'b0;
         bus_address      <= 16'h0;
         bus_wdata        <= 32'h0;
         bus_write_mask   <= 4'hF;
         bus_enable       <= 1'b0;
         bus_write_enable <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         lat_size         <= lat_size_n;
         lat_signed       <= lat_signed_n;
         lat_off          <= lat_off_n;
         req_ready        <= req_ready_n;
         rsp_valid        <= rsp_valid_n;
         rsp_rdata        <= rsp_rdata_n;
         rsp_error        <= rsp_error_n;
         bus_address      <= bus_address_n;
         bus_wdata        <= bus_wdata_n;
         bus_write_mask   <= bus_write_mask_n;
         bus_enable       <= bus_enable_n;
         bus_write_enable <= bus_write_enable_n;
      end
   end

endmodule

// File: tb/tb_memory_bus_master.sv
// Bench for memory_bus_master: random loads/stores against a lane-level memory model,
// with response and bus-window scoreboards fed at request time.
module tb_memory_bus_master;

   localparam int RW = 1;
   localparam int W  = 49;   // {exp_cycle[15:0], error, rdata[31:0]}
   localparam int BW = 57;   // {len[3:0], we, addr[15:0], mask[3:0], wdata[31:0]}
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk, reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [15:0] req_address;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;
   logic [15:0] bus_address;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_write_mask;
   logic        bus_enable, bus_write_enable;
   logic [31:0] bus_rdata = 32'h0;
   logic [1:0]  dbg_state;

   memory_bus_master #(.READ_WAIT(RW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .bus_address(bus_address), .bus_wdata(bus_wdata),
      .bus_write_mask(bus_write_mask), .bus_enable(bus_enable),
      .bus_write_enable(bus_write_enable), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [W-1:0]  exp_q[$];
   logic [BW-1:0] bus_q[$];
   logic [31:0]   ref_mem[0:16383];
   logic [31:0]   bus_mem[0:16383];
   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic ok, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // bus slave: memory updated only through the DUT's masked strobes
   always @(negedge clk) begin
      if (reset && bus_enable && bus_write_enable)
         for (int l = 0; l < 4; l++)
            if (!bus_write_mask[l]) bus_mem[bus_address[15:2]][8*l +: 8] = bus_wdata[8*l +: 8];
      bus_rdata = (bus_enable && !bus_write_enable) ? bus_mem[bus_address[15:2]] : 32'hDEADBEEF;
   end

   // monitor: bus windows and responses
   logic [BW-1:0] cur = '0;
   logic          in_win = 1'b0, win_ok = 1'b0, win_skip = 1'b0;
   int            win_len = 0;
   logic [W-1:0]  rsp_e;

   always @(negedge clk) begin
      if (!reset) begin
         in_win = 1'b0;
      end else begin
         if (bus_enable) begin
            if (!in_win) begin
               in_win = 1'b1; win_len = 0; win_ok = 1'b1; win_skip = 1'b0;
               if (bus_q.size() == 0) begin
                  check("bus_unexpected", 1'b0, {48'h0, bus_address}, 64'h0);
                  win_skip = 1'b1;
               end else begin
                  cur = bus_q.pop_front();
                  check("bus_addr", bus_address == cur[51:36], bus_address, cur[51:36]);
                  check("bus_we", bus_write_enable == cur[52], bus_write_enable, cur[52]);
                  check("bus_mask", bus_write_mask == cur[35:32], bus_write_mask, cur[35:32]);
                  if (cur[52]) check("bus_wdata", bus_wdata == cur[31:0], bus_wdata, cur[31:0]);
               end
            end
            win_len++;
            if (bus_address != cur[51:36] || bus_write_enable != cur[52] ||
                (cur[52] && bus_wdata != cur[31:0]) || (!cur[52] && bus_write_mask != 4'hF))
               win_ok = 1'b0;
         end else if (in_win) begin
            in_win = 1'b0;
            if (!win_skip) begin
               check("bus_len", win_len == int'(cur[56:53]), win_len, cur[56:53]);
               check("bus_stable", win_ok, {63'h0, win_ok}, 64'h1);
            end
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1'b0, rsp_rdata, 64'h0);
            end else begin
               rsp_e = exp_q.pop_front();
               check("rsp_cycle", 16'(cyc) == rsp_e[48:33], 16'(cyc), rsp_e[48:33]);
               check("rsp_rdata", rsp_rdata == rsp_e[31:0], rsp_rdata, rsp_e[31:0]);
               check("rsp_error", rsp_error == rsp_e[32], rsp_error, rsp_e[32]);
            end
         end
      end
   end

   // driver: presents one request, models it when the handshake is about to complete
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [31:0] d, input int gap);
      logic [31:0] word, wd, val, res;
      logic [3:0]  m;
      logic [7:0]  lane_v;
      logic        mis, err, lane_on;
      int          lat, width, base, n, acc;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_address = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("accept_timeout", 1'b0, 64'h0, 64'h1);
         req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
      err = 1'b0;
      res = 32'h0;
      if (mis && TRAP) begin
         err = 1'b1;
         lat = 1;
      end else begin
         word = ref_mem[a[15:2]];
         if (wr) begin
            m = 4'hF;
            wd = 32'h0;
            for (int l = 0; l < 4; l++) begin
               case (sz)
                  2'b00: begin lane_on = (l == int'(a[1:0])); lane_v = d[7:0]; end
                  2'b01: begin lane_on = ((l / 2) == int'(a[1])); lane_v = d[8*(l%2) +: 8]; end
                  default: begin lane_on = 1'b1; lane_v = d[8*l +: 8]; end
               endcase
               wd[8*l +: 8] = lane_v;
               if (lane_on) begin
                  m[l] = 1'b0;
                  word[8*l +: 8] = lane_v;
               end
            end
            ref_mem[a[15:2]] = word;
            lat = 2;
            bus_q.push_back({4'd1, 1'b1, a[15:2], 2'b00, m, wd});
         end else begin
            case (sz)
               2'b00:   begin width = 8;  base = int'(a[1:0]); end
               2'b01:   begin width = 16; base = a[1] ? 2 : 0; end
               default: begin width = 32; base = 0; end
            endcase
            val = word >> (8 * base);
            if (width < 32) begin
               val = val & ((32'd1 << width) - 32'd1);
               if (sg && val[width-1]) val = val - (32'd1 << width);
            end
            res = val;
            lat = RW + 2;
            bus_q.push_back({4'(RW + 1), 1'b0, a[15:2], 2'b00, 4'hF, 32'h0});
         end
      end
      exp_q.push_back({16'(acc + lat - 1), err, res});
      @(posedge clk);
      if (gap > 0) begin
         @(negedge clk);
         req_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic reset_mid_read();
      issue(1'b0, 2'b10, 1'b0, 16'h0050, 32'h0, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rst_bus_enable", bus_enable == 1'b0, bus_enable, 64'h0);
      check("rst_rsp_valid", rsp_valid == 1'b0, rsp_valid, 64'h0);
      check("rst_req_ready", req_ready == 1'b0, req_ready, 64'h0);
      check("rst_mask", bus_write_mask == 4'hF, bus_write_mask, 64'hF);
      exp_q.delete();
      bus_q.delete();
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("rel_ready_low", req_ready == 1'b0, req_ready, 64'h0);
      @(negedge clk);
      check("rel_ready_high", req_ready == 1'b1, req_ready, 64'h1);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_address = 16'h0; req_wdata = 32'h0;
      for (int i = 0; i < 16384; i++) begin
         ref_mem[i] = 32'(i) * 32'h9E3779B1;
         bus_mem[i] = 32'(i) * 32'h9E3779B1;
      end
      repeat (3) @(negedge clk);
      check("reset_req_ready", req_ready == 1'b0, req_ready, 64'h0);
      check("reset_rsp_valid", rsp_valid == 1'b0, rsp_valid, 64'h0);
      check("reset_rsp_error", rsp_error == 1'b0, rsp_error, 64'h0);
      check("reset_rsp_rdata", rsp_rdata == 32'h0, rsp_rdata, 64'h0);
      check("reset_bus_address", bus_address == 16'h0, bus_address, 64'h0);
      check("reset_bus_wdata", bus_wdata == 32'h0, bus_wdata, 64'h0);
      check("reset_bus_mask", bus_write_mask == 4'hF, bus_write_mask, 64'hF);
      check("reset_bus_enable", bus_enable == 1'b0, bus_enable, 64'h0);
      check("reset_bus_we", bus_write_enable == 1'b0, bus_write_enable, 64'h0);
      check("reset_state", dbg_state == 2'd0, dbg_state, 64'h0);
      #2 reset = 1'b1;
      #1 check("release_ready_low", req_ready == 1'b0, req_ready, 64'h0);
      @(negedge clk);
      check("release_ready_high", req_ready == 1'b1, req_ready, 64'h1);

      // directed cases from the block's usage scenarios
      issue(1'b1, 2'b10, 1'b0, 16'h0040, 32'h12345678, 1);
      issue(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, 1);
      issue(1'b1, 2'b00, 1'b0, 16'h0042, 32'h000000A5, 1);
      issue(1'b1, 2'b10, 1'b0, 16'h0040, 32'h00A50000, 1);
      issue(1'b0, 2'b00, 1'b1, 16'h0042, 32'h0, 1);
      issue(1'b0, 2'b00, 1'b0, 16'h0042, 32'h0, 1);
      issue(1'b1, 2'b10, 1'b0, 16'h0044, 32'h80017FFF, 1);
      issue(1'b0, 2'b01, 1'b1, 16'h0046, 32'h0, 1);
      issue(1'b0, 2'b01, 1'b1, 16'h0044, 32'h0, 1);
      issue(1'b0, 2'b10, 1'b0, 16'h0041, 32'h0, 1);
      issue(1'b0, 2'b01, 1'b0, 16'h0047, 32'h0, 0);
      issue(1'b1, 2'b01, 1'b0, 16'h0045, 32'h0000BEEF, 0);
      issue(1'b0, 2'b10, 1'b0, 16'h0044, 32'h0, 1);

      for (int i = 0; i < 150; i++)
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               16'(32'h40 + $urandom_range(0, 63)), $urandom, $urandom_range(0, 2));

      reset_mid_read();

      for (int i = 0; i < 30; i++)
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               16'(32'h40 + $urandom_range(0, 63)), $urandom, $urandom_range(0, 2));
      req_valid = 1'b0;

      n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0 || in_win) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("drain_rsp_queue", exp_q.size() == 0, exp_q.size(), 64'h0);
      check("drain_bus_queue", bus_q.size() == 0, bus_q.size(), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/memory_bus_master.md
# memory_bus_master

Initiator side of the CPU memory bus: accepts one load/store request at a time from the core and drives the bus signals `address`, `data_in`, `write_mask`, `bus_enable` and `write_enable`. It samples the bus read data, extracts the addressed byte or halfword and sign- or zero-extends it. Sits between the execute stage and the bank-routing bus, replacing ad-hoc bus driving in the core with a single handshaked sequencer. Requests may target any bank: RAM, ROM, peripherals or block RAM.

## Interface
- `READ_WAIT`, 1: extra cycles `bus_enable` is held before read data is sampled; legal range 0–7.
- `clk` input 1: bus clock; every register is clocked on its rising edge.
- `reset` input 1: reset is asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_signed` input 1: sign-extend load data.
- `req_address` input 16: byte address.
- `req_wdata` input 32: store data, right-justified.
- `rsp_valid` output 1: one-cycle pulse at completion.
- `rsp_rdata` output 32: extended load data; 0 for stores.
- `rsp_error` output 1: misaligned access; qualified by `rsp_valid`.
- `bus_address` output 16: to bus `address`; bits [1:0] are always 00.
- `bus_wdata` output 32: to bus `data_in`.
- `bus_write_mask` output 4: per-lane mask; bit n = 1 blocks writes to byte lane n.
- `bus_enable` output 1: to bus `bus_enable`.
- `bus_write_enable` output 1: to bus `write_enable`.
- `bus_rdata` input 32: from bus `data_out`.

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: latch the request.
  - Misaligned request → RESP with error set, and no bus activity.
  - Otherwise a store → WRITE and a load → READ, with the wait counter loaded with `READ_WAIT`.
- WRITE: one cycle with `bus_enable`=1 and `bus_write_enable`=1, then → RESP.
- READ: `bus_enable`=1 and `bus_write_enable`=0. When counter = 0, sample `bus_rdata` and go → RESP; otherwise decrement the counter.
- RESP: registered `rsp_valid`=1 for exactly one cycle, with `rsp_rdata`/`rsp_error` valid, then → IDLE.
- `req_ready`=0 in WRITE, READ and RESP.
- Store lane steering:
  - Byte: `req_wdata[7:0]` replicated to all four lanes; mask has only bit `addr[1:0]` clear.
  - Halfword: `req_wdata[15:0]` replicated to both halves; mask 4'b1100 for `addr[1]`=0, 4'b0011 for `addr[1]`=1.
  - Word: mask 4'b0000.
- Load extraction:
  - Byte: lane `addr[1:0]`.
  - Halfword: bits [15:0] when `addr[1]`=0, bits [31:16] when `addr[1]`=1.
  - Extension: bit 7 or bit 15 is replicated when `req_signed`=1; zero-extended otherwise.
  - Word: passed through unchanged; `req_signed` is ignored.
- Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. Behaviour depends on Configuration.
- Outside WRITE: `bus_write_mask`=4'hF and `bus_write_enable`=0. Outside WRITE and READ: `bus_enable`=0.

## Timing
- All outputs are registered.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_error`=0.
  - `rsp_rdata`=0, `bus_address`=0, `bus_wdata`=0.
  - `bus_write_mask`=4'hF, `bus_enable`=0, `bus_write_enable`=0.
- `req_ready` rises on the first clock after `reset` deasserts.
- Store: accept at edge N; bus strobes high during cycle N+1; `rsp_valid` in cycle N+2; `req_ready` back to 1 in cycle N+3.
- Load: accept at edge N; `bus_enable` high for READ_WAIT+1 cycles, from N+1; data is sampled at the last edge of that window; `rsp_valid` follows one cycle later. Accept-to-`rsp_valid` latency is READ_WAIT+2.
- Misaligned request: `rsp_valid` in cycle N+1.
- `bus_address` and `bus_wdata` stay stable for the whole bus window.
- Reset mid-operation: outputs immediately drop to their reset values, the request is discarded, and no `rsp_valid` is produced. A write strobe cut short by reset must not be retried.
- `req_valid` is ignored while `req_ready`=0.

## Configuration
- `MISALIGN_TRAP_EN` defined: misaligned requests complete with `rsp_error`=1, `rsp_rdata`=0, and no bus cycle.
- `MISALIGN_TRAP_EN` undefined: `rsp_error` is tied to 0. Misaligned halfword/word accesses are performed at the aligned address with the low address bits ignored: halfword uses `addr[1]` only, and word ignores `addr[1:0]`.

## Test plan
- Word store 0x12345678 to 0x0040, then word load from 0x0040 (READ_WAIT=1) → store cycle shows mask 4'h0; load `rsp_valid` arrives 3 cycles after accept with 0x12345678.
- Byte store 0xA5 to 0x0042 → `bus_wdata`=0xA5A5A5A5, mask 4'b1011. Signed byte load of a 0x00A50000 word from 0x0042 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Halfword load at 0x0046 from word 0x8001_7FFF → signed 0xFFFF8001; at 0x0044 → 0x00007FFF.
- With `MISALIGN_TRAP_EN`, word load at 0x0041 → `rsp_valid`+`rsp_error` 1 cycle after accept, and `bus_enable` never asserted. Without it, the same load returns the word at 0x0040.
- Back-to-back requests with `req_valid` held high → the second is accepted only once `req_ready` is high again after `rsp_valid`; exactly one bus window per request.
- `reset` asserted during the READ wait window → `bus_enable` is 0 immediately; no `rsp_valid`; `req_ready`=1 one clock after release.
